// File: rtl/bank_req_sched_pkg.sv
// Shared types for the per-bank request scheduler: request payload, opcodes,
// and small elaboration helpers.
package bank_req_sched_pkg;

    localparam logic [1:0] OP_WR = 2'd1;
    localparam logic [1:0] OP_RD = 2'd2;

    typedef struct packed {
        logic [63:0] addr;    // [63:62] select the bank
        logic [1:0]  opcode;
        logic [31:0] data;
    } input_req_pld_t;

    function automatic int max_w(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bank_req_sched_if.sv
// Handshake bundle between the rd/wr crossbars, the scheduler and the cache banks.
interface bank_req_sched_if #(
    parameter int BANK_NUM   = 4,
    parameter int CREDIT_NUM = 8
);
    import bank_req_sched_pkg::*;

    localparam int CRD_W = $clog2(CREDIT_NUM + 1);

    logic           [BANK_NUM-1:0]            rd_vld;
    input_req_pld_t [BANK_NUM-1:0]            rd_pld;
    logic           [BANK_NUM-1:0]            rd_rdy;
    logic           [BANK_NUM-1:0]            wr_vld;
    input_req_pld_t [BANK_NUM-1:0]            wr_pld;
    logic           [BANK_NUM-1:0]            wr_rdy;
    logic           [BANK_NUM-1:0]            bank_vld;
    input_req_pld_t [BANK_NUM-1:0]            bank_pld;
    logic           [BANK_NUM-1:0]            bank_rdy;
    logic           [BANK_NUM-1:0]            bank_credit_rtn;
    logic           [BANK_NUM-1:0][CRD_W-1:0] crd_cnt;

    modport master (
        output rd_vld, rd_pld, wr_vld, wr_pld, bank_rdy, bank_credit_rtn,
        input  rd_rdy, wr_rdy, bank_vld, bank_pld, crd_cnt
    );

    modport slave (
        input  rd_vld, rd_pld, wr_vld, wr_pld, bank_rdy, bank_credit_rtn,
        output rd_rdy, wr_rdy, bank_vld, bank_pld, crd_cnt
    );

endinterface

// File: rtl/bank_wrr_slice.sv
// One bank: weighted round-robin rd/wr pick, credit counter bounding outstanding
// requests, and a single registered output stage toward the bank.
module bank_wrr_slice
    import bank_req_sched_pkg::*;
#(
    parameter int CREDIT_NUM = 8,
    parameter int RD_WEIGHT  = 3,
    parameter int WR_WEIGHT  = 1,
    parameter int CRD_W      = $clog2(CREDIT_NUM + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_vld,
    input  input_req_pld_t   rd_pld,
    output logic             rd_rdy,
    input  logic             wr_vld,
    input  input_req_pld_t   wr_pld,
    output logic             wr_rdy,
    output logic             bank_vld,
    output input_req_pld_t   bank_pld,
    input  logic             bank_rdy,
    input  logic             credit_rtn,
    output logic [CRD_W-1:0] crd
);

    localparam int BW = $clog2(max_w(RD_WEIGHT, WR_WEIGHT)) + 1;

    localparam logic [0:0]       PH_RD   = 1'b0;
    localparam logic [0:0]       PH_WR   = 1'b1;
    localparam logic [BW-1:0]    RD_W    = BW'(RD_WEIGHT);
    localparam logic [BW-1:0]    WR_W    = BW'(WR_WEIGHT);
    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDIT_NUM);

    logic [0:0]    phase;
    logic [BW-1:0] burst;
    logic          gnt_rd;
    logic          gnt_wr;
    logic          can_acc;
    logic          acc;
    logic          same_src;

    // Current phase keeps the grant until its weight is used up, but only while
    // the other source is actually waiting.
    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (phase == PH_RD) begin
            if (rd_vld && (!wr_vld || burst < RD_W)) gnt_rd = 1'b1;
            else if (wr_vld)                         gnt_wr = 1'b1;
        end else begin
            if (wr_vld && (!rd_vld || burst < WR_W)) gnt_wr = 1'b1;
            else if (rd_vld)                         gnt_rd = 1'b1;
        end
    end

    // rst_n gating keeps rdy low while the flops are held in reset.
    assign can_acc  = rst_n && (!bank_vld || bank_rdy) && (crd != '0);
    assign rd_rdy   = can_acc && gnt_rd;
    assign wr_rdy   = can_acc && gnt_wr;
    assign acc      = rd_rdy || wr_rdy;
    assign same_src = (gnt_rd && phase == PH_RD) || (gnt_wr && phase == PH_WR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_RD;
            burst <= '0;
        end else if (acc) begin
            if (same_src) begin
                if (burst < ((phase == PH_RD) ? RD_W : WR_W)) burst <= burst + 1'b1;
            end else begin
                phase <= gnt_wr ? PH_WR : PH_RD;
                burst <= BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_vld <= 1'b0;
            bank_pld <= '0;
        end else if (acc) begin
            bank_vld <= 1'b1;
            bank_pld <= gnt_wr ? wr_pld : rd_pld;
        end else if (bank_rdy) begin
            bank_vld <= 1'b0;
        end
    end

    // Accept and return in the same cycle cancel; a stray return at full saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crd <= CRD_MAX;
        end else begin
            case ({acc, credit_rtn})
                2'b10:   crd <= crd - 1'b1;
                2'b01:   if (crd != CRD_MAX) crd <= crd + 1'b1;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            a_crd_ovf: assert (!(credit_rtn && crd == CRD_MAX))
                else $warning("bank_wrr_slice: credit returned while counter already full");
            a_rd_op: assert (!(rd_rdy && rd_pld.opcode != OP_RD))
                else $error("bank_wrr_slice: read source accepted a non-read opcode");
            a_one_gnt: assert (!(rd_rdy && wr_rdy))
                else $error("bank_wrr_slice: read and write granted together");
        end
    end

endmodule

// File: rtl/bank_req_sched.sv
// Per-bank rd/wr scheduler in front of the cache banks; every bank is an
// independent bank_wrr_slice.
module bank_req_sched
    import bank_req_sched_pkg::*;
#(
    parameter int BANK_NUM   = 4,
    parameter int CREDIT_NUM = 8,
    parameter int RD_WEIGHT  = 3,
    parameter int WR_WEIGHT  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    bank_req_sched_if.slave  bus
);

    localparam int CRD_W = $clog2(CREDIT_NUM + 1);

    for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
        logic [CRD_W-1:0] crd;

        bank_wrr_slice #(
            .CREDIT_NUM (CREDIT_NUM),
            .RD_WEIGHT  (RD_WEIGHT),
            .WR_WEIGHT  (WR_WEIGHT),
            .CRD_W      (CRD_W)
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_vld     (bus.rd_vld[g]),
            .rd_pld     (bus.rd_pld[g]),
            .rd_rdy     (bus.rd_rdy[g]),
            .wr_vld     (bus.wr_vld[g]),
            .wr_pld     (bus.wr_pld[g]),
            .wr_rdy     (bus.wr_rdy[g]),
            .bank_vld   (bus.bank_vld[g]),
            .bank_pld   (bus.bank_pld[g]),
            .bank_rdy   (bus.bank_rdy[g]),
            .credit_rtn (bus.bank_credit_rtn[g]),
            .crd        (crd)
        );

        assign bus.crd_cnt[g] = crd;
    end

endmodule

// File: tb/tb_bank_req_sched.sv
// Directed bench for bank_req_sched: per-bank scoreboard of accepted payloads
// checked against the registered bank output, plus grant-order and credit checks.
module tb_bank_req_sched;
    import bank_req_sched_pkg::*;

    localparam int BN = 4;
    localparam int CN = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bank_req_sched_if #(.BANK_NUM(BN), .CREDIT_NUM(CN)) bus ();

    bank_req_sched #(
        .BANK_NUM   (BN),
        .CREDIT_NUM (CN),
        .RD_WEIGHT  (3),
        .WR_WEIGHT  (1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [BN-1:0] rd_en, wr_en, brdy, auto_rtn, man_rtn, pend_rtn;
    logic [BN-1:0] racc, wacc, rrdy, wrdy;
    int rd_seq [BN];
    int wr_seq [BN];
    int n_acc  [BN];
    input_req_pld_t sbq  [BN][$];
    bit             glog [BN][$];

    bit pat2 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit pat3 [5] = '{0, 0, 0, 1, 0};

    function automatic input_req_pld_t mk(int b, bit w, int s);
        input_req_pld_t p;
        p.addr   = {b[1:0], 29'd0, w, s};
        p.opcode = w ? OP_WR : OP_RD;
        p.data   = {b[7:0], 7'd0, w, s[15:0]} ^ 32'h5a5a_0000;
        return p;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive sources, sample at +3 after the edge, score, advance.
    task automatic cyc();
        bus.rd_vld          = rd_en;
        bus.wr_vld          = wr_en;
        bus.bank_rdy        = brdy;
        bus.bank_credit_rtn = man_rtn | pend_rtn;
        for (int b = 0; b < BN; b++) begin
            bus.rd_pld[b] = mk(b, 1'b0, rd_seq[b]);
            bus.wr_pld[b] = mk(b, 1'b1, wr_seq[b]);
        end
        #2;
        for (int b = 0; b < BN; b++) begin
            rrdy[b] = bus.rd_rdy[b];
            wrdy[b] = bus.wr_rdy[b];
            chk($sformatf("one_gnt_b%0d", b), 128'(rrdy[b] & wrdy[b]), 128'(0));
            if (sbq[b].size() > 0) begin
                chk($sformatf("out_vld_b%0d", b), 128'(bus.bank_vld[b]), 128'(1));
                chk($sformatf("out_pld_b%0d", b), 128'(bus.bank_pld[b]), 128'(sbq[b][0]));
                if (brdy[b]) void'(sbq[b].pop_front());
            end else begin
                chk($sformatf("out_idle_b%0d", b), 128'(bus.bank_vld[b]), 128'(0));
            end
            racc[b] = bus.rd_vld[b] & rrdy[b];
            wacc[b] = bus.wr_vld[b] & wrdy[b];
            if (racc[b]) begin
                sbq[b].push_back(bus.rd_pld[b]);
                glog[b].push_back(1'b0);
                rd_seq[b]++;
                n_acc[b]++;
            end
            if (wacc[b]) begin
                sbq[b].push_back(bus.wr_pld[b]);
                glog[b].push_back(1'b1);
                wr_seq[b]++;
                n_acc[b]++;
            end
            pend_rtn[b] = auto_rtn[b] & bus.bank_vld[b] & bus.bank_rdy[b];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd_en = '0; wr_en = '0; brdy = '1;
        auto_rtn = '0; man_rtn = '0; pend_rtn = '0;
        for (int b = 0; b < BN; b++) begin
            rd_seq[b] = 0; wr_seq[b] = 0; n_acc[b] = 0;
        end

        // reset: rdy must stay low even with requests present
        #1;
        rst_n = 1'b0;
        rd_en = '1;
        wr_en = '1;
        cyc();
        chk("rst_rd_rdy", 128'(rrdy), 128'(0));
        chk("rst_wr_rdy", 128'(wrdy), 128'(0));
        for (int b = 0; b < BN; b++) begin
            chk($sformatf("rst_crd_b%0d", b), 128'(bus.crd_cnt[b]), 128'(CN));
            chk($sformatf("rst_pld_b%0d", b), 128'(bus.bank_pld[b]), 128'(0));
        end
        rd_en = '0;
        wr_en = '0;
        rst_n = 1'b1;

        // 1: read-only bank 0, no returns -> exactly CN accepts then blocked
        rd_en = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("t1_acc_c%0d", i), 128'(racc[0]), 128'(i < 8));
        end
        chk("t1_n_acc", 128'(n_acc[0]), 128'(8));
        chk("t1_crd_zero", 128'(bus.crd_cnt[0]), 128'(0));
        rd_en   = '0;
        man_rtn = 4'b0001;
        repeat (8) cyc();
        man_rtn = '0;
        chk("t1_crd_back", 128'(bus.crd_cnt[0]), 128'(CN));

        // 2: both sources on bank 2 -> R,R,R,W,R,R,R,W
        rd_en    = 4'b0100;
        wr_en    = 4'b0100;
        auto_rtn = 4'b0100;
        repeat (8) cyc();
        rd_en = '0;
        wr_en = '0;
        repeat (4) cyc();
        chk("t2_n_gnt", 128'(glog[2].size()), 128'(8));
        for (int i = 0; i < 8 && i < glog[2].size(); i++)
            chk($sformatf("t2_gnt%0d", i), 128'(glog[2][i]), 128'(pat2[i]));
        chk("t2_crd", 128'(bus.crd_cnt[2]), 128'(CN));

        // 3: stall bank 1 with a request held in the output stage
        auto_rtn = 4'b0010;
        rd_en    = 4'b0010;
        brdy     = 4'b1101;
        cyc();
        chk("t3_first_acc", 128'(racc[1]), 128'(1));
        wr_en = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("t3_rd_rdy_c%0d", i), 128'(rrdy[1]), 128'(0));
            chk($sformatf("t3_wr_rdy_c%0d", i), 128'(wrdy[1]), 128'(0));
            chk($sformatf("t3_crd_c%0d", i), 128'(bus.crd_cnt[1]), 128'(CN - 1));
        end
        brdy = '1;
        repeat (4) cyc();
        rd_en = '0;
        wr_en = '0;
        repeat (4) cyc();
        chk("t3_n_gnt", 128'(glog[1].size()), 128'(5));
        for (int i = 0; i < 5 && i < glog[1].size(); i++)
            chk($sformatf("t3_gnt%0d", i), 128'(glog[1][i]), 128'(pat3[i]));
        chk("t3_crd", 128'(bus.crd_cnt[1]), 128'(CN));

        // 4: accept+return at crd=1, then return at full saturates
        auto_rtn = '0;
        rd_en    = 4'b1000;
        repeat (7) cyc();
        chk("t4_crd_one", 128'(bus.crd_cnt[3]), 128'(1));
        man_rtn = 4'b1000;
        cyc();
        chk("t4_acc_with_rtn", 128'(racc[3]), 128'(1));
        chk("t4_crd_hold", 128'(bus.crd_cnt[3]), 128'(1));
        rd_en = '0;
        repeat (7) cyc();
        chk("t4_crd_full", 128'(bus.crd_cnt[3]), 128'(CN));
        cyc();
        chk("t4_crd_sat", 128'(bus.crd_cnt[3]), 128'(CN));
        man_rtn = '0;

        // 5: independence, bank 3 stalled while 0..2 stream
        auto_rtn = '1;
        rd_en    = 4'b1101;
        wr_en    = 4'b1110;
        brdy     = 4'b0111;
        for (int i = 0; i < 12; i++) begin
            cyc();
            for (int b = 0; b < 3; b++)
                chk($sformatf("t5_tput_b%0d_c%0d", b, i), 128'(racc[b] | wacc[b]), 128'(1));
        end
        chk("t5_crd_b3_stall", 128'(bus.crd_cnt[3]), 128'(CN - 1));
        rd_en = 4'b1000;
        wr_en = 4'b1000;
        brdy  = '1;
        repeat (3) cyc();
        rd_en = '0;
        wr_en = '0;
        repeat (4) cyc();
        for (int b = 0; b < BN; b++)
            chk($sformatf("t5_crd_b%0d", b), 128'(bus.crd_cnt[b]), 128'(CN));

        // 6: async reset mid-burst in WR phase, first grant after reset is a read
        auto_rtn = '0;
        wr_en    = 4'b0001;
        repeat (5) cyc();
        chk("t6_crd_pre", 128'(bus.crd_cnt[0]), 128'(3));
        chk("t6_vld_pre", 128'(bus.bank_vld[0]), 128'(1));
        rst_n = 1'b0;
        #2;
        chk("t6_vld_rst", 128'(bus.bank_vld[0]), 128'(0));
        chk("t6_crd_rst", 128'(bus.crd_cnt[0]), 128'(CN));
        chk("t6_pld_rst", 128'(bus.bank_pld[0]), 128'(0));
        chk("t6_wr_rdy_rst", 128'(bus.wr_rdy[0]), 128'(0));
        for (int b = 0; b < BN; b++) sbq[b].delete();
        pend_rtn = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd_en = 4'b0001;
        cyc();
        chk("t6_first_rd", 128'(racc[0]), 128'(1));
        chk("t6_first_not_wr", 128'(wacc[0]), 128'(0));
        rd_en    = '0;
        wr_en    = '0;
        auto_rtn = '1;
        repeat (3) cyc();
        chk("t6_crd_end", 128'(bus.crd_cnt[0]), 128'(CN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
